// File: rtl/multdiv_pkg.sv
// Shared constants for the MIPS multiply/divide unit: FSM encoding, operation codes
// and the iteration count.
package multdiv_pkg;
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
    localparam int   N_ITER  = 32;
endpackage

// File: rtl/unidade_multdiv.sv
// Iterative signed mult/div for the multicycle MIPS datapath. Works on magnitudes
// over 32 cycles, then fixes signs and writes HI/LO in one adjust cycle.
module unidade_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    input  logic             operacao,
    input  logic [WIDTH-1:0] entradaA,
    input  logic [WIDTH-1:0] entradaB,
    output logic             ocupado,
    output logic             pronto,
    output logic             divZero,
    output logic [WIDTH-1:0] saidaHi,
    output logic [WIDTH-1:0] saidaLo
);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg(x) : x;
    endfunction

    estado_t            estado;
    logic               op;
    logic               sinal_res;
    logic               sinal_rest;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [5:0]         cnt;

    logic [WIDTH:0]     soma;
    logic [WIDTH:0]     resto_sh;
    logic [WIDTH-1:0]   dif;
    logic [2*WIDTH-1:0] acc_prox;
    logic [2*WIDTH-1:0] prod;

    // Multiply: acc = {partial sum, multiplier}; add mag_a when the multiplier LSB is
    // set, then shift right keeping the carry. Divide: acc = {remainder, dividend/quotient};
    // shift left and subtract the divisor when it fits.
    always_comb begin
        soma     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : '0)};
        resto_sh = acc[2*WIDTH-1:WIDTH-1];
        dif      = resto_sh[WIDTH-1:0] - mag_b;
        acc_prox = {soma, acc[WIDTH-1:1]};
        if (op == OP_DIV) begin
            if (resto_sh >= {1'b0, mag_b})
                acc_prox = {dif, acc[WIDTH-2:0], 1'b1};
            else
                acc_prox = {resto_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        prod = sinal_res ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            op         <= OP_MULT;
            sinal_res  <= 1'b0;
            sinal_rest <= 1'b0;
            mag_a      <= '0;
            mag_b      <= '0;
            acc        <= '0;
            cnt        <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
            divZero    <= 1'b0;
            saidaHi    <= '0;
            saidaLo    <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        op      <= operacao;
                        cnt     <= '0;
                        divZero <= 1'b0;
                        // Divide by zero skips the datapath and leaves HI/LO intact.
                        if (operacao == OP_DIV && entradaB == '0) begin
                            divZero <= 1'b1;
                            pronto  <= 1'b1;
                            estado  <= FIM;
                        end else begin
                            mag_a      <= abs_val(entradaA);
                            mag_b      <= abs_val(entradaB);
                            sinal_res  <= entradaA[WIDTH-1] ^ entradaB[WIDTH-1];
                            sinal_rest <= entradaA[WIDTH-1];
                            acc        <= {{WIDTH{1'b0}},
                                           (operacao == OP_DIV) ? abs_val(entradaA) : abs_val(entradaB)};
                            ocupado    <= 1'b1;
                            estado     <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_prox;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(N_ITER - 1))
                        estado <= AJUSTE;
                end
                AJUSTE: begin
                    if (op == OP_MULT) begin
                        saidaHi <= prod[2*WIDTH-1:WIDTH];
                        saidaLo <= prod[WIDTH-1:0];
                    end else begin
                        saidaLo <= sinal_res  ? neg(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                        saidaHi <= sinal_rest ? neg(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
                    end
                    ocupado <= 1'b0;
                    pronto  <= 1'b1;
                    estado  <= FIM;
                end
                FIM: begin
                    pronto <= 1'b0;
                    estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_multdiv.sv
// Scoreboard bench for unidade_multdiv: stimulus pushes expected HI/LO/flag/latency
// from a plain-arithmetic model; a monitor pops and compares on every pronto pulse.
module tb_unidade_multdiv;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0;
    logic        operacao = 1'b0;
    logic [31:0] entradaA = '0;
    logic [31:0] entradaB = '0;
    logic        ocupado, pronto, divZero;
    logic [31:0] saidaHi, saidaLo;

    unidade_multdiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .inicio(inicio), .operacao(operacao),
        .entradaA(entradaA), .entradaB(entradaB), .ocupado(ocupado),
        .pronto(pronto), .divZero(divZero), .saidaHi(saidaHi), .saidaLo(saidaLo)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    endtask

    // Reference: signed 64-bit arithmetic; C-style / and % truncate toward zero.
    task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b, input int acc_cyc);
        exp_t   e;
        longint sa, sb, p, qq, r;
        sa = $signed(a);
        sb = $signed(b);
        e.dz = 1'b0;
        e.due = acc_cyc + 33;
        if (op == 1'b0) begin
            p = sa * sb;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
            e.due = acc_cyc;
        end else begin
            qq = sa / sb;
            r  = sa % sb;
            m_lo = qq[31:0];
            m_hi = r[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && pronto === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pronto got=1 want=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", saidaHi, e.hi);
                chk("lo", saidaLo, e.lo);
                chk("divZero", {31'b0, divZero}, {31'b0, e.dz});
                chk("latency_cycle", cyc, e.due);
                chk("ocupado_with_pronto", {31'b0, ocupado}, 32'd0);
            end
        end
    end

    task automatic wait_idle(output bit ok);
        int guard = 0;
        @(negedge clock);
        while ((ocupado || pronto) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        ok = (guard < 200);
        if (!ok) begin
            checks++;
            $display("FAIL idle_timeout got=busy want=idle (t=%0t)", $time);
        end
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        wait_idle(ok);
        if (!ok) return;
        inicio = 1'b1; operacao = op; entradaA = a; entradaB = b;
        push(op, a, b, cyc + 1);
        @(posedge clock); #1;
        inicio = 1'b0; entradaA = $urandom; entradaB = $urandom;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($signed($urandom_range(0, 200)) - 100);
            2: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ocupado"}, {31'b0, ocupado}, 32'd0);
        chk({tag, "_pronto"}, {31'b0, pronto}, 32'd0);
        chk({tag, "_divZero"}, {31'b0, divZero}, 32'd0);
        chk({tag, "_hi"}, saidaHi, 32'd0);
        chk({tag, "_lo"}, saidaLo, 32'd0);
    endtask

    initial begin
        bit ok;
        int n_acc;
        int guard;
        logic [31:0] a, b;

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        // Abort a multiply at iteration 10 with a one-edge reset pulse.
        @(negedge clock);
        inicio = 1'b1; operacao = 1'b0; entradaA = 32'd7; entradaB = 32'd6;
        @(posedge clock); #1;
        inicio = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("midop_busy", {31'b0, ocupado}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_zero("midop_reset");
        reset = 1'b0;
        m_hi = '0; m_lo = '0;

        issue(1'b0, 32'd7, 32'd6);
        issue(1'b0, 32'hFFFF_FFFD, 32'd5);
        issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        issue(1'b1, 32'h0000_00BA, 32'h0000_0010);
        issue(1'b1, 32'd5, 32'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);

        // inicio held through a whole multiply while operands churn; second start at N+35.
        wait_idle(ok);
        if (ok) begin
            a = $urandom; b = $urandom;
            inicio = 1'b1; operacao = 1'b0; entradaA = a; entradaB = b;
            n_acc = cyc + 1;
            push(1'b0, a, b, n_acc);
            @(posedge clock);
            guard = 0;
            forever begin
                @(negedge clock);
                guard++;
                if (cyc == n_acc + 34 || guard > 100) break;
                operacao = 1'($urandom_range(0, 1));
                entradaA = $urandom; entradaB = $urandom;
            end
            a = rand_operand(); b = rand_operand();
            if (b == 32'd0) b = 32'd3;
            operacao = 1'b1; entradaA = a; entradaB = b;
            push(1'b1, a, b, n_acc + 35);
            @(posedge clock); #1;
            inicio = 1'b0;
        end

        for (int i = 0; i < 25; i++) begin
            a = rand_operand();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_operand();
            issue(1'($urandom_range(0, 1)), a, b);
        end

        guard = 0;
        while ((q.size() != 0 || pronto || ocupado) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain got=%0d want=0 pending results", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
